// File: rtl/fft_pkg.sv
// Shared definitions for the 4-point FFT streaming controller: FSM states,
// frame size and default sample width.
package fft_pkg;
    localparam int POINTS         = 4;
    localparam int IDX_W          = 2;
    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;
endpackage

// File: rtl/fft4_stream_ctrl.sv
// Serial-to-parallel frame buffer around an external 4-point FFT: collects four
// samples, launches the FFT, captures its eight result words and streams them out.
module fft4_stream_ctrl
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TIMEOUT    = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] in_real,
    input  logic signed [DATA_WIDTH-1:0] in_imag,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] fft_in0_real,
    output logic signed [DATA_WIDTH-1:0] fft_in0_imag,
    output logic signed [DATA_WIDTH-1:0] fft_in1_real,
    output logic signed [DATA_WIDTH-1:0] fft_in1_imag,
    output logic signed [DATA_WIDTH-1:0] fft_in2_real,
    output logic signed [DATA_WIDTH-1:0] fft_in2_imag,
    output logic signed [DATA_WIDTH-1:0] fft_in3_real,
    output logic signed [DATA_WIDTH-1:0] fft_in3_imag,
    output logic                         fft_en,
    input  logic signed [DATA_WIDTH+1:0] fft_out0_real,
    input  logic signed [DATA_WIDTH+1:0] fft_out0_imag,
    input  logic signed [DATA_WIDTH+1:0] fft_out1_real,
    input  logic signed [DATA_WIDTH+1:0] fft_out1_imag,
    input  logic signed [DATA_WIDTH+1:0] fft_out2_real,
    input  logic signed [DATA_WIDTH+1:0] fft_out2_imag,
    input  logic signed [DATA_WIDTH+1:0] fft_out3_real,
    input  logic signed [DATA_WIDTH+1:0] fft_out3_imag,
    input  logic                         fft_valid,
    output logic signed [DATA_WIDTH+1:0] out_real,
    output logic signed [DATA_WIDTH+1:0] out_imag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic [IDX_W-1:0]             out_index,
    output logic                         busy,
    output logic                         err_timeout
);
    localparam int OW = DATA_WIDTH + 2;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state, next_state;
    idx_t            wr_cnt, rd_cnt;
    logic [TW-1:0]   timer;
    logic            timeout_hit;

    logic signed [DATA_WIDTH-1:0] ibuf_re [POINTS];
    logic signed [DATA_WIDTH-1:0] ibuf_im [POINTS];
    logic signed [OW-1:0]         obuf_re [POINTS];
    logic signed [OW-1:0]         obuf_im [POINTS];
    logic signed [OW-1:0]         fo_re   [POINTS];
    logic signed [OW-1:0]         fo_im   [POINTS];

    assign fo_re[0] = fft_out0_real;  assign fo_im[0] = fft_out0_imag;
    assign fo_re[1] = fft_out1_real;  assign fo_im[1] = fft_out1_imag;
    assign fo_re[2] = fft_out2_real;  assign fo_im[2] = fft_out2_imag;
    assign fo_re[3] = fft_out3_real;  assign fo_im[3] = fft_out3_imag;

    // Input buffer is only written in FILL, so the FFT sees a stable frame until capture.
    assign fft_in0_real = ibuf_re[0];  assign fft_in0_imag = ibuf_im[0];
    assign fft_in1_real = ibuf_re[1];  assign fft_in1_imag = ibuf_im[1];
    assign fft_in2_real = ibuf_re[2];  assign fft_in2_imag = ibuf_im[2];
    assign fft_in3_real = ibuf_re[3];  assign fft_in3_imag = ibuf_im[3];

    assign in_ready  = (state == FILL);
    assign busy      = (state != FILL);
    assign fft_en    = (state == LAUNCH);
    assign out_valid = (state == DRAIN);
    assign out_index = rd_cnt;
    assign out_last  = (state == DRAIN) && (rd_cnt == idx_t'(POINTS - 1));
    assign out_real  = obuf_re[rd_cnt];
    assign out_imag  = obuf_im[rd_cnt];

    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        unique case (state)
            FILL:   if (in_valid && wr_cnt == idx_t'(POINTS - 1)) next_state = LAUNCH;
            LAUNCH: next_state = WAIT;
            WAIT: begin
                // A result arriving on the last allowed cycle still wins over the timeout.
                if (fft_valid) begin
                    next_state = DRAIN;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    next_state  = FILL;
                    timeout_hit = 1'b1;
                end
            end
            DRAIN:  if (out_ready && rd_cnt == idx_t'(POINTS - 1)) next_state = FILL;
            default: next_state = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            timer       <= '0;
            err_timeout <= 1'b0;
            for (int k = 0; k < POINTS; k++) begin
                ibuf_re[k] <= '0;
                ibuf_im[k] <= '0;
                obuf_re[k] <= '0;
                obuf_im[k] <= '0;
            end
        end else begin
            state       <= next_state;
            err_timeout <= timeout_hit;
            timer       <= (state == WAIT && next_state == WAIT) ? timer + 1'b1 : '0;
            if (in_valid && in_ready) begin
                ibuf_re[wr_cnt] <= in_real;
                ibuf_im[wr_cnt] <= in_imag;
                wr_cnt          <= wr_cnt + 1'b1;
            end
            if (state == WAIT && fft_valid) begin
                for (int k = 0; k < POINTS; k++) begin
                    obuf_re[k] <= fo_re[k];
                    obuf_im[k] <= fo_im[k];
                end
            end
            if (out_valid && out_ready) rd_cnt <= rd_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fft4_stream_ctrl.sv
// Directed bench for fft4_stream_ctrl with a behavioural 2-cycle fft4 attached
// and a scoreboard of expected output bins.
module tb_fft4_stream_ctrl;
    localparam int DW = 8;
    localparam int OW = DW + 2;

    logic clk = 1'b0;
    logic rst_n;
    logic signed [DW-1:0] in_real, in_imag;
    logic in_valid, in_ready;
    logic signed [DW-1:0] fi0r, fi0i, fi1r, fi1i, fi2r, fi2i, fi3r, fi3i;
    logic fft_en;
    logic signed [OW-1:0] fo_r [4];
    logic signed [OW-1:0] fo_i [4];
    logic fft_valid;
    logic signed [OW-1:0] out_real, out_imag;
    logic out_valid, out_ready, out_last;
    logic [1:0] out_index;
    logic busy, err_timeout;

    always #5 clk = ~clk;

    fft4_stream_ctrl #(.DATA_WIDTH(DW), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_real(in_real), .in_imag(in_imag), .in_valid(in_valid), .in_ready(in_ready),
        .fft_in0_real(fi0r), .fft_in0_imag(fi0i), .fft_in1_real(fi1r), .fft_in1_imag(fi1i),
        .fft_in2_real(fi2r), .fft_in2_imag(fi2i), .fft_in3_real(fi3r), .fft_in3_imag(fi3i),
        .fft_en(fft_en),
        .fft_out0_real(fo_r[0]), .fft_out0_imag(fo_i[0]), .fft_out1_real(fo_r[1]), .fft_out1_imag(fo_i[1]),
        .fft_out2_real(fo_r[2]), .fft_out2_imag(fo_i[2]), .fft_out3_real(fo_r[3]), .fft_out3_imag(fo_i[3]),
        .fft_valid(fft_valid),
        .out_real(out_real), .out_imag(out_imag), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_index(out_index), .busy(busy), .err_timeout(err_timeout)
    );

    // Behavioural fft4: results appear two cycles after the launch strobe.
    bit   fft_on = 1'b1;
    bit   stray  = 1'b0;
    logic p1 = 1'b0, fv = 1'b0;
    assign fft_valid = fv | stray;
    always @(posedge clk) begin
        p1 <= fft_en && fft_on;
        fv <= p1;
        if (fft_en) begin
            fo_r[0] <= fi0r + fi1r + fi2r + fi3r;
            fo_i[0] <= fi0i + fi1i + fi2i + fi3i;
            fo_r[1] <= fi0r + fi1i - fi2r - fi3i;
            fo_i[1] <= fi0i - fi1r - fi2i + fi3r;
            fo_r[2] <= fi0r - fi1r + fi2r - fi3r;
            fo_i[2] <= fi0i - fi1i + fi2i - fi3i;
            fo_r[3] <= fi0r - fi1i - fi2r + fi3i;
            fo_i[3] <= fi0i + fi1r - fi2i - fi3r;
        end
    end

    typedef struct { int re; int im; int idx; bit last; } exp_t;
    exp_t sbq[$];
    int   n_assert = 0, n_fail = 0;
    int   fft_en_cnt = 0, err_cnt = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void dft(input int r[4], input int i[4], output int xr[4], output int xi[4]);
        xr[0] = r[0] + r[1] + r[2] + r[3];   xi[0] = i[0] + i[1] + i[2] + i[3];
        xr[1] = r[0] + i[1] - r[2] - i[3];   xi[1] = i[0] - r[1] - i[2] + r[3];
        xr[2] = r[0] - r[1] + r[2] - r[3];   xi[2] = i[0] - i[1] + i[2] - i[3];
        xr[3] = r[0] - i[1] - r[2] + i[3];   xi[3] = i[0] + r[1] - i[2] - r[3];
    endfunction

    // Output monitor: pops the scoreboard on every output handshake.
    bit last_seen = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (fft_en) fft_en_cnt++;
            if (err_timeout) err_cnt++;
            if (last_seen) check("in_ready_after_last", in_ready, 1);
            last_seen = 1'b0;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_bin", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("out_real", $signed(out_real), e.re);
                    check("out_imag", $signed(out_imag), e.im);
                    check("out_index", out_index, e.idx);
                    check("out_last", out_last, e.last);
                    if (out_last) last_seen = 1'b1;
                end
            end
        end
    end

    task automatic send_sample(input int re, input int im);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_real  = DW'(re);
        in_imag  = DW'(im);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic send_frame(input int r[4], input int i[4], input bit gap, input bit push);
        int xr[4], xi[4];
        dft(r, i, xr, xi);
        if (push)
            for (int k = 0; k < 4; k++) sbq.push_back('{xr[k], xi[k], k, k == 3});
        for (int k = 0; k < 4; k++) begin
            send_sample(r[k], i[k]);
            if (gap && k < 3) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !busy) begin ok = 1'b1; break; end
        end
        check(tag, ok, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fr[4], fi[4], xr[4], xi[4];
        int en0;
        bit ov, got;
        rst_n = 1'b0; in_valid = 1'b0; in_real = '0; in_imag = '0; out_ready = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_fft_en", fft_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_err", err_timeout, 0);
        check("rst_out_real", $signed(out_real), 0);
        check("rst_fft_in0", $signed(fi0r), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Impulse frame
        fr = '{1, 0, 0, 0}; fi = '{0, 0, 0, 0};
        en0 = fft_en_cnt;
        send_frame(fr, fi, 1'b0, 1'b1);
        wait_idle("impulse_drain");
        check("impulse_fft_en_once", fft_en_cnt - en0, 1);

        // DC frame
        fr = '{2, 2, 2, 2}; fi = '{0, 0, 0, 0};
        send_frame(fr, fi, 1'b0, 1'b1);
        wait_idle("dc_drain");

        // General frame back-to-back, then the same frame gapped
        fr = '{3, -7, 10, -1}; fi = '{-2, 5, 1, -8};
        send_frame(fr, fi, 1'b0, 1'b1);
        wait_idle("general_drain");
        send_frame(fr, fi, 1'b1, 1'b1);
        wait_idle("gapped_drain");

        // fft_valid outside WAIT must be ignored
        stray = 1'b1; @(posedge clk); #1; stray = 1'b0;
        @(negedge clk);
        check("stray_busy", busy, 0);
        check("stray_out_valid", out_valid, 0);
        @(posedge clk); #1;

        // Backpressure on bin 1
        out_ready = 1'b0;
        send_frame(fr, fi, 1'b0, 1'b1);
        dft(fr, fi, xr, xi);
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid) begin got = 1'b1; break; end
        end
        check("bp_wait_valid", got, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_index", out_index, 1);
            check("bp_real", $signed(out_real), xr[1]);
            check("bp_imag", $signed(out_imag), xi[1]);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_idle("bp_drain");

        // Timeout with fft_valid never arriving
        fft_on = 1'b0;
        ov = 1'b0;
        fr = '{4, 3, 2, 1}; fi = '{0, 0, 0, 0};
        send_frame(fr, fi, 1'b0, 1'b0);
        check("to_launch", fft_en, 1);
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            if (out_valid) ov = 1'b1;
            if (k == 15) check("to_err_early", err_timeout, 0);
            if (k == 16) begin
                check("to_err_pulse", err_timeout, 1);
                check("to_back_fill", busy, 0);
            end
            if (k == 17) check("to_err_single", err_timeout, 0);
        end
        check("to_no_out_valid", ov, 0);
        fft_on = 1'b1;

        // Reset after two accepted samples, then a full frame
        send_sample(1, 1);
        send_sample(5, 5);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_fft_in1", $signed(fi1r), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        fr = '{-128, -128, -128, -128}; fi = '{127, 127, 127, 127};
        send_frame(fr, fi, 1'b0, 1'b1);
        wait_idle("postrst_drain");

        check("fft_en_total", fft_en_cnt, 7);
        check("err_total", err_cnt, 1);
        check("sb_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fft4_stream_ctrl.md
FFT4_STREAM_CTRL -- requirements
Module: fft4_stream_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: sample width of the real and imaginary parts, two's complement.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles spent in WAIT for fft_valid.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_real, in_imag  in  DATA_WIDTH each  serial input sample, signed.
REQ-006 in_valid  in  1 / in_ready  out  1  input handshake; a sample is accepted when both are high.
REQ-007 fft_in0..3_real, fft_in0..3_imag  out  DATA_WIDTH each  parallel frame driven to the 4-point FFT, in natural (arrival) order.
REQ-008 fft_en  out  1  launch strobe to the FFT.
REQ-009 fft_out0..3_real, fft_out0..3_imag  in  DATA_WIDTH+2 each  FFT results; fft_valid  in  1  results valid.
REQ-010 out_real, out_imag  out  DATA_WIDTH+2 each  serial result sample, signed.
REQ-011 out_valid  out  1 / out_ready  in  1  output handshake; out_last  out  1  marks bin 3; out_index  out  2  bin number.
REQ-012 busy  out  1  high in every state except FILL; err_timeout  out  1  one-cycle error pulse.

Function
REQ-013 The FSM SHALL have four states: FILL, LAUNCH, WAIT, and DRAIN.
REQ-014 In FILL, in_ready SHALL be 1, and each accepted sample SHALL be stored at slot wr_cnt (0..3), after which wr_cnt increments.
REQ-015 Acceptance of slot 3 SHALL move the FSM to LAUNCH on the next cycle, with wr_cnt wrapping to 0.
REQ-016 In LAUNCH, fft_en SHALL be 1 for exactly one cycle, after which the FSM moves to WAIT.
REQ-017 fft_in* SHALL hold the buffered frame, stable from LAUNCH until the results are captured.
REQ-018 In WAIT, when fft_valid=1, all 8 result words SHALL be captured into the output buffer and the FSM SHALL move to DRAIN.
REQ-019 No latency assumption SHALL be made about the FFT; the 2-cycle fft4 latency is the nominal case.
REQ-020 If fft_valid has not arrived after TIMEOUT cycles in WAIT, err_timeout SHALL pulse for one cycle, the frame SHALL be discarded, and the FSM SHALL return to FILL.
REQ-021 fft_valid outside WAIT SHALL be ignored.
REQ-022 In DRAIN, out_valid SHALL be 1 and out_real/out_imag SHALL present bin rd_cnt, with out_index=rd_cnt and out_last=(rd_cnt==3).
REQ-023 While out_valid=1 and out_ready=0, all output signals SHALL hold stable.
REQ-024 A handshake on bin 3 SHALL return the FSM to FILL on the next cycle, with rd_cnt wrapping to 0; in_ready SHALL be high in that cycle.
REQ-025 Minimum frame period SHALL be 4 (fill) + 1 (launch) + L (FFT latency) + 4 (drain) cycles.
REQ-026 Input is not accepted during LAUNCH, WAIT, or DRAIN (in_ready=0), so in_valid in those states SHALL have no effect.
REQ-027 No arithmetic SHALL be performed; widths pass through unchanged, with DATA_WIDTH+2 output growth owned by the FFT.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately set: state=FILL, wr_cnt=rd_cnt=timer=0, in_ready=1, fft_en=0, out_valid=0, out_last=0, out_index=0, err_timeout=0, busy=0.
REQ-029 On reset, fft_in*, out_real, and out_imag SHALL be 0.
REQ-030 Reset mid-frame SHALL discard any partial input and pending results; after release, the first accepted sample SHALL be slot 0.

Structure
REQ-031 A shared package fft_pkg SHALL hold the state enumeration, POINTS=4, the index width (2), and the default DATA_WIDTH.
REQ-032 The block SHALL be a single module with no sub-module; the fft4 instance SHALL live in the parent, not inside this controller.

Verification
REQ-033 Impulse frame: (1,0),(0,0),(0,0),(0,0) with fft4 attached and out_ready=1 SHALL give bins 0..3 all (1,0), with out_last on bin 3 and fft_en pulsed exactly once.
REQ-034 DC frame: four samples of (2,0) SHALL give (8,0),(0,0),(0,0),(0,0), and the first in_ready=1 after the frame SHALL occur the cycle after the bin-3 handshake.
REQ-035 Backpressure: out_ready=0 for 5 cycles on bin 1 SHALL hold out_real/out_imag/out_index stable, and no bin SHALL be lost or duplicated.
REQ-036 Timeout: with fft_valid tied 0 and a full frame entered, err_timeout SHALL pulse 15 cycles after WAIT entry, the FSM SHALL return to FILL, and out_valid SHALL never rise.
REQ-037 Reset after 2 accepted samples, followed by a new full frame (-128,127)x4, SHALL give (-512,508),(0,0),(0,0),(0,0).
REQ-038 Gapped input (in_valid toggling every other cycle) SHALL give frame results identical to back-to-back input.
